instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/instruction_fetch_fetch_buffer.sv | 48 ++++
 rtl/instruction_fetch.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP word,
// sequential PC step and the redirect target calculation.
package instruction_fetch_pkg;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_KILL = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    // jump_reg outranks jump_target, which outranks the conditional branch.
    function automatic logic [31:0] redirect_target(
        input logic        [31:0] pc_id,
        input logic        [31:0] instr_id,
        input logic        [31:0] jr_pc,
        input logic signed [31:0] branch_offset,
        input logic               jump_reg,
        input logic               jump_target
    );
        logic [31:0] pc_plus4;
        pc_plus4 = pc_id + PC_INC;
        if (jump_reg)
            return jr_pc & 32'hFFFF_FFFC;
        else if (jump_target)
            return (pc_plus4 & 32'hF000_0000) | ((instr_id << 2) & 32'h0FFF_FFFC);
        return pc_plus4 + $unsigned(branch_offset);
    endfunction

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// One-entry pc/instruction holding register that parks an imem response
// while decode is stalled.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage with one outstanding imem request and the IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to deliver the sequential delay slot after a redirect.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump_branch,
    input  logic               jump_target,
    input  logic               jump_reg,
    input  logic signed [31:0] branch_offset,
    input  logic        [31:0] jr_pc,
    output logic               imem_req,
    output logic        [31:0] imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic        [31:0] imem_rdata,
    output logic        [31:0] pc_id,
    output logic        [31:0] instr_id,
    output logic               valid_id
);

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;

    logic        buf_load, buf_clear, buf_valid;
    logic [31:0] buf_pc, buf_instr;
    logic        accept, redirect, rsp_valid, kill_on_rst;
    logic [31:0] tgt;

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (req_pc_q),
        .load_instr (imem_rdata),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    assign accept      = ~valid_id_q | ~stall;
    assign redirect    = valid_id_q & ~stall & (jump_branch | jump_target);
    assign rsp_valid   = (state_q == ST_WAIT) & imem_rvalid;
    assign tgt         = redirect_target(pc_id_q, instr_id_q, jr_pc, branch_offset,
                                         jump_reg, jump_target);
    // A request already accepted by imem must have its response swallowed.
    assign kill_on_rst = ((state_q == ST_WAIT) | (state_q == ST_KILL)) & ~imem_rvalid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (imem_ready) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    state_d    = ST_WAIT;
                    if (pend_q) begin
                        fetch_pc_d = pend_tgt_q;
                        pend_d     = 1'b0;
`ifndef BRANCH_DELAY_SLOT_EN
                        state_d    = ST_KILL;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d  = accept ? ST_REQ : ST_HOLD;
                    buf_load = ~accept;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d   = ST_REQ;
                    buf_clear = 1'b1;
                end
            end
            default: begin
                if (imem_rvalid)
                    state_d = ST_REQ;
            end
        endcase

        if (accept) begin
            if (buf_valid) begin
                pc_id_d    = buf_pc;
                instr_id_d = buf_instr;
                valid_id_d = 1'b1;
            end else if (rsp_valid) begin
                pc_id_d    = req_pc_q;
                instr_id_d = imem_rdata;
                valid_id_d = 1'b1;
            end else begin
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
            end
        end

        // The address of a presented-but-unaccepted request must not move,
        // so a redirect arriving then waits in the pending register.
        if (redirect) begin
            if ((state_q == ST_REQ) & ~imem_ready) begin
                pend_d     = 1'b1;
                pend_tgt_d = tgt;
            end else begin
                fetch_pc_d = tgt;
            end
`ifndef BRANCH_DELAY_SLOT_EN
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            buf_clear  = 1'b1;
            if (((state_q == ST_WAIT) & ~imem_rvalid) | ((state_q == ST_REQ) & imem_ready))
                state_d = ST_KILL;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= kill_on_rst ? ST_KILL : ST_REQ;
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pc_id_q    <= '0;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q   <= req_pc_d;
        pend_tgt_q <= pend_tgt_d;
    end

    assign imem_req  = (state_q == ST_REQ) & ~rst;
    assign imem_addr = fetch_pc_q & 32'hFFFF_FFFC;
    assign pc_id     = pc_id_q;
    assign instr_id  = instr_id_q;
    assign valid_id  = valid_id_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: imem model returns the address as data.
module tb_instruction_fetch;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               jump_branch, jump_target, jump_reg;
    logic signed [31:0] branch_offset;
    logic        [31:0] jr_pc;
    logic               imem_req;
    logic        [31:0] imem_addr;
    logic               imem_ready, imem_rvalid;
    logic        [31:0] imem_rdata;
    logic        [31:0] pc_id, instr_id;
    logic               valid_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ready_en;
    int          mem_lat;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;

    logic [1:0]  jmode;
    logic [31:0] jsrc;
    logic        hit;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump_branch   (jump_branch),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .branch_offset (branch_offset),
        .jr_pc         (jr_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_id         (pc_id),
        .instr_id      (instr_id),
        .valid_id      (valid_id)
    );

    always #5 clk = ~clk;

    assign imem_ready  = ready_en;
    assign imem_rvalid = mem_busy && (mem_cnt == 0);
    assign imem_rdata  = mem_addr;

    always @(posedge clk) begin
        if (imem_req && imem_ready) begin
            mem_busy <= 1'b1;
            mem_addr <= imem_addr;
            mem_cnt  <= mem_lat - 1;
        end else if (imem_rvalid) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Decode stand-in: jmode 1 = BEQ taken, 2 = J, 3 = JR, fired when jsrc reaches ID.
    assign hit           = valid_id && (pc_id == jsrc);
    assign jump_branch   = hit && (jmode == 2'd1);
    assign jump_target   = hit && (jmode == 2'd2 || jmode == 2'd3);
    assign jump_reg      = hit && (jmode == 2'd3);
    assign branch_offset = 32'sh0000_0020;
    assign jr_pc         = 32'h0000_0103;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_redirect(input logic [1:0] mode, input logic [31:0] src,
                                input logic [31:0] tgt, input string nm);
        jmode = mode;
        jsrc  = src;
        do_reset();
        repeat (src / 2 + 2) tick();
        check({nm, "_src_pc"}, pc_id, src);
        check({nm, "_src_valid"}, 32'(valid_id), 32'd1);
        tick();
        check({nm, "_bubble"}, 32'(valid_id), 32'd0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        check({nm, "_slot_pc"}, pc_id, src + 32'd4);
        check({nm, "_slot_valid"}, 32'(valid_id), 32'd1);
`else
        check({nm, "_still_bubble"}, 32'(valid_id), 32'd0);
`endif
        check({nm, "_tgt_addr"}, imem_addr, tgt);
        check({nm, "_tgt_req"}, 32'(imem_req), 32'd1);
        tick();
        tick();
        check({nm, "_tgt_pc"}, pc_id, tgt);
        check({nm, "_tgt_instr"}, instr_id, tgt);
        check({nm, "_tgt_valid"}, 32'(valid_id), 32'd1);
        jmode = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; ready_en = 1'b1; mem_lat = 1;
        jmode = 2'd0; jsrc = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_valid_id", 32'(valid_id), 32'd0);
        check("rst_instr_id", instr_id, 32'h0);
        check("rst_pc_id", pc_id, 32'h0);
        check("rst_req_low", 32'(imem_req), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);

        // Zero-wait sequential fetch
        for (int j = 0; j < 4; j++) begin
            tick();
            check("seq_wait_no_req", 32'(imem_req), 32'd0);
            tick();
            check("seq_pc_id", pc_id, 32'(4 * j));
            check("seq_instr_id", instr_id, 32'(4 * j));
            check("seq_valid", 32'(valid_id), 32'd1);
            check("seq_next_addr", imem_addr, 32'(4 * j + 4));
        end

        // Three-cycle stall while the word at 0x10 returns
        stall = 1'b1;
        tick();
        check("stall_hold_pc1", pc_id, 32'hC);
        tick();
        check("stall_hold_noreq", 32'(imem_req), 32'd0);
        check("stall_hold_pc2", pc_id, 32'hC);
        tick();
        check("stall_hold_noreq2", 32'(imem_req), 32'd0);
        check("stall_hold_instr", instr_id, 32'hC);
        stall = 1'b0;
        tick();
        check("drain_pc", pc_id, 32'h10);
        check("drain_instr", instr_id, 32'h10);
        check("drain_valid", 32'(valid_id), 32'd1);
        check("drain_next_addr", imem_addr, 32'h14);
        check("drain_req", 32'(imem_req), 32'd1);

        // Redirects: BEQ, J, JR
        run_redirect(2'd1, 32'h10, 32'h34, "beq");
        run_redirect(2'd2, 32'h18, 32'h60, "j");
        run_redirect(2'd3, 32'h40, 32'h100, "jr");

        // imem_ready low for four cycles with address 0x8 presented
        do_reset();
        repeat (4) tick();
        check("rdy_addr_start", imem_addr, 32'h8);
        ready_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rdy_low_addr", imem_addr, 32'h8);
            check("rdy_low_req", 32'(imem_req), 32'd1);
        end
        ready_en = 1'b1;
        tick();
        tick();
        check("rdy_resume_pc", pc_id, 32'h8);
        check("rdy_resume_instr", instr_id, 32'h8);

        // Reset while the request for 0x4 is outstanding
        do_reset();
        tick();
        tick();
        mem_lat = 3;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("kill_no_req", 32'(imem_req), 32'd0);
        check("kill_valid", 32'(valid_id), 32'd0);
        tick();
        tick();
        check("kill_discard_valid", 32'(valid_id), 32'd0);
        check("kill_restart_req", 32'(imem_req), 32'd1);
        check("kill_restart_addr", imem_addr, 32'h0);
        mem_lat = 1;
        tick();
        tick();
        check("kill_first_pc", pc_id, 32'h0);
        check("kill_first_instr", instr_id, 32'h0);
        check("kill_first_valid", 32'(valid_id), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
